// File: rtl/data_buffer_if.sv
// Bus between the controller/data cache and the data_buffer operand collector.
// The slave modport is the buffer side, the master modport is the driver side.
interface data_buffer_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NUM_FMAS   = 4
);
  logic                           load_start_in;
  logic [1:0]                     load_sel_in;
  logic                           cache_valid_in;
  logic [WORD_WIDTH-1:0]          cache_word_in;
  logic                           buffer_ready_out;
  logic                           issue_in;
  logic                           fma_valid_out;
  logic [NUM_FMAS*WORD_WIDTH-1:0] fma_a_out;
  logic [NUM_FMAS*WORD_WIDTH-1:0] fma_b_out;
  logic [NUM_FMAS*WORD_WIDTH-1:0] fma_c_out;
  logic                           busy_out;

  modport slave (
    input  load_start_in, load_sel_in, cache_valid_in, cache_word_in, issue_in,
    output buffer_ready_out, fma_valid_out, fma_a_out, fma_b_out, fma_c_out, busy_out
  );

  modport master (
    output load_start_in, load_sel_in, cache_valid_in, cache_word_in, issue_in,
    input  buffer_ready_out, fma_valid_out, fma_a_out, fma_b_out, fma_c_out, busy_out
  );
endinterface

// File: rtl/data_buffer.sv
// data_buffer: collects NUM_FMAS cache words into operand bank A, B or C and issues all
// three banks to the FMA array on command.
// Optional feature macro: DATA_BUFFER_AUTO_ISSUE_EN -- a fill that completes bank C
// issues automatically on the cycle after the ready pulse.
module data_buffer #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NUM_FMAS   = 4
) (
  input logic          clk_in,
  input logic          rst_in,
  data_buffer_if.slave bus
);

  localparam int unsigned CntW = (NUM_FMAS > 1) ? $clog2(NUM_FMAS) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(NUM_FMAS - 1);
  localparam logic [1:0] SelC = 2'd2;

  typedef enum logic [1:0] {StIdle, StFill, StDone, StIssue} state_e;

  state_e                state_q, state_d;
  logic [1:0]            sel_q;
  logic [CntW-1:0]       cnt_q;
  logic [WORD_WIDTH-1:0] bank_q [3][NUM_FMAS];

  logic fill_wr;
  logic last_word;
  logic start_fill;

  assign fill_wr    = (state_q == StFill) && bus.cache_valid_in;
  assign last_word  = fill_wr && (cnt_q == LastLane);
  assign start_fill = (state_q == StIdle) && (state_d == StFill);

  // Next-state decode and state-derived pulse outputs.
  always_comb begin
    state_d              = state_q;
    bus.buffer_ready_out = 1'b0;
    bus.fma_valid_out    = 1'b0;
    bus.busy_out         = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        // Issue has priority over a simultaneous load request.
        if (bus.issue_in) begin
          state_d = StIssue;
        end else if (bus.load_start_in && (bus.load_sel_in != 2'd3)) begin
          state_d = StFill;
        end
      end
      StFill: begin
        if (last_word) state_d = StFill == StFill ? StDone : StFill;
      end
      StDone: begin
        bus.buffer_ready_out = 1'b1;
`ifdef DATA_BUFFER_AUTO_ISSUE_EN
        state_d = (sel_q == SelC) ? StIssue : StIdle;
`else
        state_d = StIdle;
`endif
      end
      StIssue: begin
        bus.fma_valid_out = 1'b1;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Bank select latch and lane counter; counter holds on the last lane instead of wrapping.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_q <= 2'd0;
      cnt_q <= '0;
    end else if (start_fill) begin
      sel_q <= bus.load_sel_in;
      cnt_q <= '0;
    end else if (fill_wr && !last_word) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Operand banks; only the selected bank's current lane is written during a fill.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int b = 0; b < 3; b++) begin
        for (int k = 0; k < NUM_FMAS; k++) begin
          bank_q[b][k] <= '0;
        end
      end
    end else if (fill_wr) begin
      bank_q[sel_q][cnt_q] <= bus.cache_word_in;
    end
  end

  // Banks drive the FMA operand buses directly; consumers qualify with fma_valid_out.
  for (genvar k = 0; k < NUM_FMAS; k++) begin : g_lane
    assign bus.fma_a_out[k*WORD_WIDTH +: WORD_WIDTH] = bank_q[0][k];
    assign bus.fma_b_out[k*WORD_WIDTH +: WORD_WIDTH] = bank_q[1][k];
    assign bus.fma_c_out[k*WORD_WIDTH +: WORD_WIDTH] = bank_q[2][k];
  end

endmodule

// File: tb/tb_data_buffer.sv
// Scoreboard bench for data_buffer: the driver updates a transaction-level model and queues
// expected ready/issue pulses; a monitor pops and compares whenever the DUT pulses.
module tb_data_buffer;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_buffer_if #(.WORD_WIDTH(W), .NUM_FMAS(N)) bus ();

  data_buffer #(.WORD_WIDTH(W), .NUM_FMAS(N)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cycle;
    logic [N*W-1:0]   a;
    logic [N*W-1:0]   b;
    logic [N*W-1:0]   c;
  } issue_t;

  int     ready_q[$];
  issue_t issue_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  bit     mon_en  = 1'b0;

  // Transaction-level model: filling flag, target bank, words so far, first cycle a
  // command is accepted again, and the three banks.
  bit               m_fill;
  int               m_sel;
  int               m_cnt;
  int               m_free;
  logic [W-1:0]     m_bank [3][N];

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N*W-1:0] packb(input int b);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = m_bank[b][k];
    return r;
  endfunction

  task automatic model_reset();
    m_fill = 0; m_sel = 0; m_cnt = 0; m_free = 0;
    for (int b = 0; b < 3; b++) for (int k = 0; k < N; k++) m_bank[b][k] = '0;
  endtask

  // One clock of stimulus: check the currently visible state, drive inputs, advance the model.
  task automatic step(input bit ld, input int sel, input bit v, input logic [W-1:0] w,
                      input bit iss);
    int     t;
    issue_t e;
    @(negedge clk);
    t = cyc;
    check("busy", N*W'(bus.busy_out), N*W'(m_fill || (t < m_free)));
    check("bank_a", bus.fma_a_out, packb(0));
    check("bank_b", bus.fma_b_out, packb(1));
    check("bank_c", bus.fma_c_out, packb(2));
    bus.load_start_in  = ld;
    bus.load_sel_in    = 2'(sel);
    bus.cache_valid_in = v;
    bus.cache_word_in  = w;
    bus.issue_in       = iss;
    if (m_fill) begin
      if (v) begin
        m_bank[m_sel][m_cnt] = w;
        m_cnt++;
        if (m_cnt == N) begin
          m_fill = 0;
          ready_q.push_back(t + 1);
          m_free = t + 2;
`ifdef DATA_BUFFER_AUTO_ISSUE_EN
          if (m_sel == 2) begin
            e.cycle = t + 2; e.a = packb(0); e.b = packb(1); e.c = packb(2);
            issue_q.push_back(e);
            m_free = t + 3;
          end
`endif
        end
      end
    end else if (t >= m_free) begin
      if (iss) begin
        e.cycle = t + 1; e.a = packb(0); e.b = packb(1); e.c = packb(2);
        issue_q.push_back(e);
        m_free = t + 2;
      end else if (ld && sel != 3) begin
        m_fill = 1; m_sel = sel; m_cnt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.load_start_in = 0; bus.cache_valid_in = 0; bus.issue_in = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: every pulse must match the head of its queue; overdue entries are misses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ready_q.size() > 0 && ready_q[0] < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL ready_missing: got no pulse expected pulse at cycle %0d", ready_q[0]);
        void'(ready_q.pop_front());
      end
      if (bus.buffer_ready_out) begin
        n_tests++;
        if (ready_q.size() == 0 || ready_q[0] != cyc) begin
          n_fail++;
          $display("FAIL ready_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          void'(ready_q.pop_front());
        end
      end
      if (issue_q.size() > 0 && issue_q[0].cycle < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL issue_missing: got no pulse expected pulse at cycle %0d", issue_q[0].cycle);
        void'(issue_q.pop_front());
      end
      if (bus.fma_valid_out) begin
        if (issue_q.size() == 0 || issue_q[0].cycle != cyc) begin
          n_tests++; n_fail++;
          $display("FAIL issue_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          check("issue_a", bus.fma_a_out, issue_q[0].a);
          check("issue_b", bus.fma_b_out, issue_q[0].b);
          check("issue_c", bus.fma_c_out, issue_q[0].c);
          void'(issue_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.load_start_in = 0; bus.load_sel_in = 0; bus.cache_valid_in = 0;
    bus.cache_word_in = '0; bus.issue_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state held while idle.
    idle(5);
    check("ready_idle", N*W'(bus.buffer_ready_out), '0);
    check("valid_idle", N*W'(bus.fma_valid_out), '0);

    // Back-to-back fill of A.
    step(1, 0, 0, '0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, W'(i), 0);
    idle(2);
    check("fill_a", bus.fma_a_out, 64'h0004_0003_0002_0001);

    // Fill of B with two-cycle gaps.
    step(1, 1, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, W'(16'h0B00 + i), 0);
      if (i < 3) idle(2);
    end
    idle(2);
    check("fill_b", bus.fma_b_out, 64'h0B03_0B02_0B01_0B00);
    check("a_kept", bus.fma_a_out, 64'h0004_0003_0002_0001);

    // Fill C with 0x00FF, then explicit issue.
    step(1, 2, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h00FF, 0);
    idle(3);
    step(0, 0, 0, '0, 1);
    idle(3);
    check("fill_c", bus.fma_c_out, 64'h00FF_00FF_00FF_00FF);

    // Mid-fill issue and reload are ignored; stray valid in idle writes nothing.
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 16'hAAA0, 0);
    step(0, 0, 1, 16'hAAA1, 1);
    step(1, 1, 1, 16'hAAA2, 0);
    step(0, 0, 1, 16'hAAA3, 0);
    idle(2);
    step(0, 1, 1, 16'hDEAD, 0);
    step(0, 3, 1, 16'hBEEF, 0);
    step(1, 3, 0, '0, 0);
    idle(2);
    step(1, 1, 0, '0, 1);
    idle(3);
    check("mid_fill_a", bus.fma_a_out, 64'hAAA3_AAA2_AAA1_AAA0);

    // Reset in the middle of a fill clears everything.
    step(1, 1, 0, '0, 0);
    step(0, 0, 1, 16'h1111, 0);
    step(0, 0, 1, 16'h2222, 0);
    do_reset();
    idle(2);
    check("rst_a", bus.fma_a_out, '0);
    check("rst_b", bus.fma_b_out, '0);
    check("rst_c", bus.fma_c_out, '0);

    // Bank C completion (auto-issue when enabled).
    step(1, 2, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, W'(16'hC000 + i), 0);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           W'($urandom), $urandom_range(0, 7) == 0);
    end
    idle(6);
    check("ready_drain", N*W'(ready_q.size()), '0);
    check("issue_drain", N*W'(issue_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end
endmodule
